floo_reduction_in_buffer: RTL and testbench
===========================================

// Module: floo_reduction_in_buffer
// PURPOSE
//  Per-route input buffer directly upstream of the reduction arbiter.
//  - Decouples each input route from the reduction stage with a small FIFO.
//  - A response arriving early on one route does not back-pressure that link.
//  - The arbiter sees stable head flits per route until it has collected all expected responses.
//  - Also flags routes whose head flit has waited too long (missing partner responses).
// PARAMETERS
//  NumRoutes     1     number of input routes / FIFOs
//  Depth         2     entries per route FIFO (>=1)
//  TimeoutCycles 1024  wait cycles of a head flit before timeout_o[r] (>=1)
//  flit_t        logic flit type passed through unmodified
// PORTS
//  clk_i      in   1                        clock; all state updates on rising edge
//  rst_i      in   1                        reset; synchronous, active-high
//  valid_i    in   NumRoutes                per-route input valid (from router input ports)
//  ready_o    out  NumRoutes                per-route input ready
//  data_i     in   NumRoutes x flit_t       per-route input flit
//  valid_o    out  NumRoutes                per-route head valid (to reduction arbiter)
//  ready_i    in   NumRoutes                per-route pop from arbiter
//  data_o     out  NumRoutes x flit_t       per-route head flit
//  fill_o     out  NumRoutes x idx_width(Depth+1)  per-route occupancy
//  timeout_o  out  NumRoutes                head flit waited >= TimeoutCycles
// BEHAVIOUR
//  Reset (rst_i=1 at an edge): all FIFOs empty, pointers/counters 0.
//   - Outputs: valid_o=0, ready_o=all 1s, fill_o=0, timeout_o=0; data_o don't-care (driven 0).
//   - Reset mid-operation drops all stored flits; no handshake is completed in the reset cycle.
//  Routes are fully independent. Per route r:
//   - Push when valid_i[r]&ready_o[r]; ready_o[r] = (fill<Depth).
//   - ready_o[r] depends only on state, never combinationally on ready_i[r].
//   - Pop when valid_o[r]&ready_i[r]; valid_o[r] = (fill>0); data_o[r] = FIFO head.
//   - Latency: flit pushed in cycle t is visible on data_o in t+1 at the earliest; no fall-through.
//   - Full: ready_o=0 even if a pop happens in the same cycle; the pop frees the slot for t+1.
//   - Empty: simultaneous push+pop impossible (valid_o=0); push lands, valid_o=1 next cycle.
//   - Push+pop same cycle (0<fill<Depth): fill unchanged, both pointers advance.
//   - Pointers wrap modulo Depth; order is strict FIFO.
//   - data_o is stable while valid_o[r]=1 and no pop occurs.
//   - AXI-stream rule: once valid_o asserts, it stays asserted until popped.
//  Wait counter per route, width idx_width(TimeoutCycles+1):
//   - Cleared to 0 on a pop or while the FIFO is empty.
//   - Else, while valid_o[r]&!ready_i[r], increments by 1 and saturates at TimeoutCycles.
//   - timeout_o[r] = (cnt==TimeoutCycles), registered; deasserts the cycle after the head pops.
//   - timeout_o is a status flag only; it never drops or modifies flits.
//  No combinational path from valid_i/data_i to valid_o/data_o, or from ready_i to ready_o.
// TESTING
//  1. NumRoutes=2, Depth=2: push A on r0 at t0, B on r1 at t3, ready_i=11 ->
//     valid_o[0]=1 from t1, valid_o[1]=1 from t4, both pop at t4; fill_o returns to 0 at t5.
//  2. Fill r0 (Depth=2) with ready_i=0 -> ready_o[0]=0 after 2 pushes, fill_o=2.
//     Push+pop in the same cycle while full -> pop accepted, push refused, ready_o[0]=1 next cycle.
//  3. Stream 10 flits 0..9 on r0 with random ready_i/valid_i -> output order 0..9, none lost.
//     Pointer wrap exercised at Depth=2 and Depth=3.
//  4. TimeoutCycles=4: hold head on r1 with ready_i[1]=0 -> timeout_o[1]=1 from 5th cycle after
//     valid_o[1] rise. Pop -> timeout_o[1]=0 next cycle; counter restarts at 0 for the next head.
//  5. Assert rst_i one cycle with fill=2 on both routes -> next cycle valid_o=00, ready_o=11,
//     fill_o=0, timeout_o=00; old flits never reappear.
//  6. Simultaneous push on all routes while every FIFO pops (fill=1) -> fills stay 1, heads advance.

Source files
------------

// File: rtl/floo_reduction_in_buffer.sv
// -----------------------------------------------------------------------------
// floo_reduction_in_buffer
//
// Per-route input buffer that sits directly upstream of the reduction arbiter.
// Each input route has its own small FIFO. Because of this, a response that
// arrives early on one route never back-pressures its link, and the arbiter
// sees a stable head flit per route until it pops it. A per-route wait counter
// flags heads that have been waiting too long, for example because partner
// responses are missing.
//
// Parameters
//   NumRoutes     number of input routes / FIFOs
//   Depth         entries per route FIFO (>= 1)
//   TimeoutCycles wait cycles of a head flit before timeout_o[r] (>= 1)
//   flit_t        flit type, passed through unmodified
//
// Ports
//   clk_i      clock; all state updates on the rising edge
//   rst_i      synchronous active-high reset
//   valid_i    per-route input valid (from the router input ports)
//   ready_o    per-route input ready; high while the FIFO has a free slot
//   data_i     per-route input flit
//   valid_o    per-route head valid (to the reduction arbiter)
//   ready_i    per-route pop request from the arbiter
//   data_o     per-route head flit; driven 0 while the FIFO is empty
//   fill_o     per-route occupancy (0..Depth)
//   timeout_o  head flit has waited >= TimeoutCycles; status flag only
// -----------------------------------------------------------------------------
module floo_reduction_in_buffer #(
  parameter int unsigned NumRoutes     = 1,
  parameter int unsigned Depth         = 2,
  parameter int unsigned TimeoutCycles = 1024,
  parameter type         flit_t        = logic
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic  [NumRoutes-1:0]                        valid_i,
  output logic  [NumRoutes-1:0]                        ready_o,
  input  flit_t [NumRoutes-1:0]                        data_i,
  output logic  [NumRoutes-1:0]                        valid_o,
  input  logic  [NumRoutes-1:0]                        ready_i,
  output flit_t [NumRoutes-1:0]                        data_o,
  output logic  [NumRoutes-1:0][$clog2(Depth+1)-1:0]   fill_o,
  output logic  [NumRoutes-1:0]                        timeout_o
);

  localparam int unsigned FillW = $clog2(Depth + 1);
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = $clog2(TimeoutCycles + 1);

  localparam logic [FillW-1:0] FillFull = FillW'(Depth);
  localparam logic [PtrW-1:0]  PtrLast  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0]  CntMax   = CntW'(TimeoutCycles);

  for (genvar r = 0; r < NumRoutes; r++) begin : g_route

    flit_t            mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FillW-1:0] fill_q, fill_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             not_empty_s;
    logic             not_full_s;
    logic             push_s;
    logic             pop_s;

    // All handshake outputs decode registered state only. This means ready_o
    // never depends on ready_i and valid_o never depends on valid_i.
    assign not_empty_s  = (fill_q != {FillW{1'b0}});
    assign not_full_s   = (fill_q < FillFull);
    assign push_s       = valid_i[r] & not_full_s;
    assign pop_s        = not_empty_s & ready_i[r];

    assign ready_o[r]   = not_full_s;
    assign valid_o[r]   = not_empty_s;
    assign data_o[r]    = not_empty_s ? mem_q[rd_ptr_q] : flit_t'(0);
    assign fill_o[r]    = fill_q;
    assign timeout_o[r] = timeout_q;

    // Next-state logic: pointers, occupancy and head wait counter.
    always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      fill_d    = fill_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;

      if (push_s) begin
        wr_ptr_d = (wr_ptr_q == PtrLast) ? {PtrW{1'b0}} : wr_ptr_q + PtrW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = (rd_ptr_q == PtrLast) ? {PtrW{1'b0}} : rd_ptr_q + PtrW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   fill_d = fill_q + FillW'(1);
        2'b01:   fill_d = fill_q - FillW'(1);
        default: fill_d = fill_q;
      endcase

      // A head that is not popped while valid is necessarily stalled. For
      // that reason, "valid & !ready" reduces to "not empty and no pop" here.
      if (pop_s || !not_empty_s) begin
        cnt_d = {CntW{1'b0}};
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end else begin
        cnt_d = cnt_q;
      end

      // Registering the compare on cnt_d makes timeout_o line up with the
      // counter value it represents.
      timeout_d = (cnt_d == CntMax);
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wr_ptr_q  <= {PtrW{1'b0}};
        rd_ptr_q  <= {PtrW{1'b0}};
        fill_q    <= {FillW{1'b0}};
        cnt_q     <= {CntW{1'b0}};
        timeout_q <= 1'b0;
      end else begin
        wr_ptr_q  <= wr_ptr_d;
        rd_ptr_q  <= rd_ptr_d;
        fill_q    <= fill_d;
        cnt_q     <= cnt_d;
        timeout_q <= timeout_d;
      end
    end

    // Flit storage. It has no reset, because data_o is masked while empty.
    // Writes are blocked during reset so that no handshake completes then.
    always_ff @(posedge clk_i) begin
      if (!rst_i && push_s) begin
        mem_q[wr_ptr_q] <= data_i[r];
      end
    end

  end

endmodule

// File: tb/tb_floo_reduction_in_buffer.sv
module tb_floo_reduction_in_buffer;

  typedef logic [7:0] flit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: two routes, Depth 2, timeout 4
  logic  [1:0]      a_valid_i, a_ready_o, a_valid_o, a_ready_i, a_timeout_o;
  flit_t [1:0]      a_data_i, a_data_o;
  logic  [1:0][1:0] a_fill_o;

  // DUT B: one route, Depth 3 (pointer wrap at a non power-of-two depth)
  logic  [0:0]      b_valid_i, b_ready_o, b_valid_o, b_ready_i, b_timeout_o;
  flit_t [0:0]      b_data_i, b_data_o;
  logic  [0:0][1:0] b_fill_o;

  floo_reduction_in_buffer #(
    .NumRoutes(2), .Depth(2), .TimeoutCycles(4), .flit_t(flit_t)
  ) dut_a (
    .clk_i(clk), .rst_i(rst),
    .valid_i(a_valid_i), .ready_o(a_ready_o), .data_i(a_data_i),
    .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o),
    .fill_o(a_fill_o), .timeout_o(a_timeout_o)
  );

  floo_reduction_in_buffer #(
    .NumRoutes(1), .Depth(3), .TimeoutCycles(4), .flit_t(flit_t)
  ) dut_b (
    .clk_i(clk), .rst_i(rst),
    .valid_i(b_valid_i), .ready_o(b_ready_o), .data_i(b_data_i),
    .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o),
    .fill_o(b_fill_o), .timeout_o(b_timeout_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One vector = inputs applied in a cycle plus the outputs expected in that
  // same cycle. The outputs reflect the state left by the previous rows.
  typedef struct {
    logic       rst;
    logic [1:0] vin;
    logic [1:0] rin;
    flit_t      d0, d1;
    logic       chk_en;
    logic [1:0] ev, er;
    logic [1:0] ef0, ef1;
    flit_t      ed0, ed1;
    logic [1:0] eto;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rs, logic [1:0] vin, logic [1:0] rin, flit_t d0, flit_t d1,
                              logic ce, logic [1:0] ev, logic [1:0] er, logic [1:0] ef0,
                              logic [1:0] ef1, flit_t ed0, flit_t ed1, logic [1:0] eto);
    vec_t v;
    v.rst = rs; v.vin = vin; v.rin = rin; v.d0 = d0; v.d1 = d1; v.chk_en = ce;
    v.ev = ev; v.er = er; v.ef0 = ef0; v.ef1 = ef1; v.ed0 = ed0; v.ed1 = ed1; v.eto = eto;
    return v;
  endfunction

  initial begin
    a_valid_i = 2'b00; a_ready_i = 2'b00; a_data_i = '0;
    b_valid_i = 1'b0;  b_ready_i = 1'b0;  b_data_i = '0;

    //             rst   vin    rin    d0     d1     chk   ev     er     f0     f1     ed0    ed1    to
    vecs.push_back(mk(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b11, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00));
    // two-route latency: A on r0 at t0, B on r1 at t3, both pop at t4
    vecs.push_back(mk(1'b0, 2'b01, 2'b00, 8'hA1, 8'h00, 1'b1, 2'b00, 2'b11, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b01, 2'b11, 2'd1, 2'd0, 8'hA1, 8'h00, 2'b00));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b01, 2'b11, 2'd1, 2'd0, 8'hA1, 8'h00, 2'b00));
    vecs.push_back(mk(1'b0, 2'b10, 2'b00, 8'h00, 8'hB2, 1'b1, 2'b01, 2'b11, 2'd1, 2'd0, 8'hA1, 8'h00, 2'b00));
    vecs.push_back(mk(1'b0, 2'b00, 2'b11, 8'h00, 8'h00, 1'b1, 2'b11, 2'b11, 2'd1, 2'd1, 8'hA1, 8'hB2, 2'b00));
    // fill r0, then push+pop while full: pop accepted, push (33) refused
    vecs.push_back(mk(1'b0, 2'b01, 2'b00, 8'h11, 8'h00, 1'b1, 2'b00, 2'b11, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00));
    vecs.push_back(mk(1'b0, 2'b01, 2'b00, 8'h22, 8'h00, 1'b1, 2'b01, 2'b11, 2'd1, 2'd0, 8'h11, 8'h00, 2'b00));
    vecs.push_back(mk(1'b0, 2'b01, 2'b01, 8'h33, 8'h00, 1'b1, 2'b01, 2'b10, 2'd2, 2'd0, 8'h11, 8'h00, 2'b00));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b01, 2'b11, 2'd1, 2'd0, 8'h22, 8'h00, 2'b00));
    vecs.push_back(mk(1'b0, 2'b00, 2'b01, 8'h00, 8'h00, 1'b1, 2'b01, 2'b11, 2'd1, 2'd0, 8'h22, 8'h00, 2'b00));
    // push on all routes while every FIFO pops at fill 1
    vecs.push_back(mk(1'b0, 2'b11, 2'b00, 8'h44, 8'h55, 1'b1, 2'b00, 2'b11, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00));
    vecs.push_back(mk(1'b0, 2'b11, 2'b11, 8'h66, 8'h77, 1'b1, 2'b11, 2'b11, 2'd1, 2'd1, 8'h44, 8'h55, 2'b00));
    // timeout on r1: head 77 is new at t13, timeout expected at t17
    vecs.push_back(mk(1'b0, 2'b00, 2'b01, 8'h00, 8'h00, 1'b1, 2'b11, 2'b11, 2'd1, 2'd1, 8'h66, 8'h77, 2'b00));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b10, 2'b11, 2'd0, 2'd1, 8'h00, 8'h77, 2'b00));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b10, 2'b11, 2'd0, 2'd1, 8'h00, 8'h77, 2'b00));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b10, 2'b11, 2'd0, 2'd1, 8'h00, 8'h77, 2'b00));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b10, 2'b11, 2'd0, 2'd1, 8'h00, 8'h77, 2'b10));
    vecs.push_back(mk(1'b0, 2'b00, 2'b10, 8'h00, 8'h00, 1'b1, 2'b10, 2'b11, 2'd0, 2'd1, 8'h00, 8'h77, 2'b10));
    // pop clears the flag; counter restarts for the next head 88
    vecs.push_back(mk(1'b0, 2'b10, 2'b00, 8'h00, 8'h88, 1'b1, 2'b00, 2'b11, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b10, 2'b11, 2'd0, 2'd1, 8'h00, 8'h88, 2'b00));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b10, 2'b11, 2'd0, 2'd1, 8'h00, 8'h88, 2'b00));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b10, 2'b11, 2'd0, 2'd1, 8'h00, 8'h88, 2'b00));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b10, 2'b11, 2'd0, 2'd1, 8'h00, 8'h88, 2'b00));
    // fill both routes to 2, then reset mid-operation
    vecs.push_back(mk(1'b0, 2'b11, 2'b00, 8'h91, 8'h92, 1'b1, 2'b10, 2'b11, 2'd0, 2'd1, 8'h00, 8'h88, 2'b10));
    vecs.push_back(mk(1'b0, 2'b01, 2'b00, 8'h93, 8'h00, 1'b1, 2'b11, 2'b01, 2'd1, 2'd2, 8'h91, 8'h88, 2'b10));
    vecs.push_back(mk(1'b1, 2'b11, 2'b11, 8'h99, 8'h99, 1'b1, 2'b11, 2'b00, 2'd2, 2'd2, 8'h91, 8'h88, 2'b10));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b11, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b11, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      a_valid_i = vecs[i].vin;
      a_ready_i = vecs[i].rin;
      a_data_i  = {vecs[i].d1, vecs[i].d0};
      #1;
      if (vecs[i].chk_en) begin
        chk($sformatf("row%0d valid_o", i),   32'(a_valid_o),   32'(vecs[i].ev));
        chk($sformatf("row%0d ready_o", i),   32'(a_ready_o),   32'(vecs[i].er));
        chk($sformatf("row%0d fill0", i),     32'(a_fill_o[0]), 32'(vecs[i].ef0));
        chk($sformatf("row%0d fill1", i),     32'(a_fill_o[1]), 32'(vecs[i].ef1));
        chk($sformatf("row%0d data0", i),     32'(a_data_o[0]), 32'(vecs[i].ed0));
        chk($sformatf("row%0d data1", i),     32'(a_data_o[1]), 32'(vecs[i].ed1));
        chk($sformatf("row%0d timeout_o", i), 32'(a_timeout_o), 32'(vecs[i].eto));
      end
    end

    // Streaming: flits 0..9 with random valid/ready into A route 0 (Depth 2)
    // and into B (Depth 3). Order and completeness are checked per pop.
    begin
      int a_sent = 0, a_recv = 0, b_sent = 0, b_recv = 0;
      for (int cyc = 0; cyc < 400 && (a_recv < 10 || b_recv < 10); cyc++) begin
        @(negedge clk);
        rst          = 1'b0;
        a_valid_i[1] = 1'b0;
        a_ready_i[1] = 1'b0;
        a_valid_i[0] = (a_sent < 10) && ($urandom_range(0, 3) != 0);
        a_data_i[0]  = 8'(a_sent);
        a_ready_i[0] = ($urandom_range(0, 2) != 0);
        b_valid_i[0] = (b_sent < 10) && ($urandom_range(0, 3) != 0);
        b_data_i[0]  = 8'(b_sent);
        b_ready_i[0] = ($urandom_range(0, 2) != 0);
        #1;
        if (a_valid_o[0] && a_ready_i[0]) begin
          chk("stream A order", 32'(a_data_o[0]), 32'(a_recv));
          a_recv++;
        end
        if (b_valid_o[0] && b_ready_i[0]) begin
          chk("stream B order", 32'(b_data_o[0]), 32'(b_recv));
          b_recv++;
        end
        if (a_valid_i[0] && a_ready_o[0]) a_sent++;
        if (b_valid_i[0] && b_ready_o[0]) b_sent++;
      end
      chk("stream A count", 32'(a_recv), 32'd10);
      chk("stream B count", 32'(b_recv), 32'd10);
      @(negedge clk);
      a_valid_i = 2'b00; a_ready_i = 2'b00;
      b_valid_i = 1'b0;  b_ready_i = 1'b0;
      #1;
      chk("stream A drained fill", 32'(a_fill_o[0]), 32'd0);
      chk("stream B drained fill", 32'(b_fill_o[0]), 32'd0);
      chk("stream B valid_o", 32'(b_valid_o), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
